// File: rtl/proj_pkg.sv
// Shared types and default physics constants for the dog's projectile.
package proj_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLIGHT = 2'd1,
        LANDED = 2'd2
    } proj_state_t;

    // Screen coordinate; negative y means the sprite is above the visible area.
    typedef logic signed [11:0] coord_t;

    localparam int          P_X_LAUNCH    = 876;
    localparam int          P_Y_LAUNCH    = 380;
    localparam int          P_GROUND_Y    = 560;
    localparam int          P_X_MIN       = 0;
    localparam int          P_VX_SHIFT    = 2;
    localparam int          P_VY0         = 12;
    localparam int          P_GRAVITY     = 1;
    localparam int          P_PROJ_SIZE   = 16;
    localparam logic [11:0] P_PROJ_COLOR  = 12'h840;
    localparam int          P_HOLD_FRAMES = 30;

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle: timing counters, syncs, blanking and colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/proj_kinematics.sv
// Per-frame ballistic update of the projectile position, with ground and
// left-wall clamping. Reports a landing combinationally on the stepping cycle.
module proj_kinematics
    import proj_pkg::*;
#(
    parameter int X_LAUNCH = P_X_LAUNCH,
    parameter int Y_LAUNCH = P_Y_LAUNCH,
    parameter int GROUND_Y = P_GROUND_Y,
    parameter int X_MIN    = P_X_MIN,
    parameter int VY0      = P_VY0,
    parameter int GRAVITY  = P_GRAVITY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_vx,
    output coord_t     o_x,
    output coord_t     o_y,
    output logic       o_landed,
    output coord_t     o_land_x
);

    localparam coord_t C_X_LAUNCH = coord_t'(X_LAUNCH);
    localparam coord_t C_Y_LAUNCH = coord_t'(Y_LAUNCH);
    localparam coord_t C_GROUND   = coord_t'(GROUND_Y);
    localparam coord_t C_X_MIN    = coord_t'(X_MIN);
    localparam coord_t C_VY_START = coord_t'(-VY0);
    localparam coord_t C_GRAVITY  = coord_t'(GRAVITY);

    coord_t     r_x;
    coord_t     r_y;
    coord_t     r_vy;
    logic [7:0] r_vx;

    coord_t     w_nx;
    coord_t     w_ny;
    coord_t     w_fx;
    coord_t     w_fy;
    logic       w_ground;
    logic       w_wall;

    // Candidate next position and the clamped landing position; ground wins over the wall.
    always_comb begin
        w_nx     = r_x - coord_t'({4'b0000, r_vx});
        w_ny     = r_y + r_vy;
        w_ground = (w_ny >= C_GROUND);
        w_wall   = (w_nx <= C_X_MIN);
        w_fx     = w_nx;
        w_fy     = w_ny;
        if (w_ground) begin
            w_fx = (w_nx < C_X_MIN) ? C_X_MIN : w_nx;
            w_fy = C_GROUND;
        end else if (w_wall) begin
            w_fx = C_X_MIN;
        end
    end

    // Load launch state, or advance one frame; clamped values double as the unclamped step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x  <= '0;
            r_y  <= '0;
            r_vy <= '0;
            r_vx <= '0;
        end else if (i_load) begin
            r_x  <= C_X_LAUNCH;
            r_y  <= C_Y_LAUNCH;
            r_vy <= C_VY_START;
            r_vx <= i_vx;
        end else if (i_step) begin
            r_x  <= w_fx;
            r_y  <= w_fy;
            r_vy <= r_vy + C_GRAVITY;
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_landed = i_step & (w_ground | w_wall);
    assign o_land_x = w_fx;

endmodule

// File: rtl/draw_projectile_dog.sv
// Dog projectile stage of the VGA draw chain: launch/flight/hold FSM, frame
// tick detection, square sprite overlay and a one-cycle output register stage.
module draw_projectile_dog
    import proj_pkg::*;
#(
    parameter int          X_LAUNCH    = P_X_LAUNCH,
    parameter int          Y_LAUNCH    = P_Y_LAUNCH,
    parameter int          GROUND_Y    = P_GROUND_Y,
    parameter int          X_MIN       = P_X_MIN,
    parameter int          VX_SHIFT    = P_VX_SHIFT,
    parameter int          VY0         = P_VY0,
    parameter int          GRAVITY     = P_GRAVITY,
    parameter int          PROJ_SIZE   = P_PROJ_SIZE,
    parameter logic [11:0] PROJ_COLOR  = P_PROJ_COLOR,
    parameter int          HOLD_FRAMES = P_HOLD_FRAMES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        launch,
    input  logic [9:0]  throw_force,
    output logic        busy,
    output logic        done,
    output logic [10:0] land_x,
    vga_if.vga_in       vga_in,
    vga_if.vga_out      vga_out
);

    localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_FRAMES - 1);

    proj_state_t r_state;
    logic        r_busy;
    logic        r_done;
    logic [10:0] r_land_x;
    logic [7:0]  r_hold;
    logic        r_vblnk_prev;

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic [11:0] r_rgb;

    logic        w_tick;
    logic        w_load;
    logic        w_step;
    logic [7:0]  w_vx;
    coord_t      w_x;
    coord_t      w_y;
    logic        w_landed;
    coord_t      w_land_x;
    logic        w_active;

    logic signed [12:0] w_h;
    logic signed [12:0] w_v;
    logic signed [12:0] w_x13;
    logic signed [12:0] w_y13;

    assign w_tick = vga_in.vblnk & ~r_vblnk_prev;
    assign w_load = (r_state == IDLE) & launch & (|throw_force);
    assign w_step = w_tick & (r_state == FLIGHT);
    assign w_vx   = 8'(throw_force >> VX_SHIFT);

    proj_kinematics #(
        .X_LAUNCH (X_LAUNCH),
        .Y_LAUNCH (Y_LAUNCH),
        .GROUND_Y (GROUND_Y),
        .X_MIN    (X_MIN),
        .VY0      (VY0),
        .GRAVITY  (GRAVITY)
    ) u_kin (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_vx     (w_vx),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_landed (w_landed),
        .o_land_x (w_land_x)
    );

    // Remember last vblnk so its rising edge marks exactly one tick per frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vblnk_prev <= 1'b0;
        end else begin
            r_vblnk_prev <= vga_in.vblnk;
        end
    end

    // Throw lifecycle: accept a launch, fly until landing, hold the sprite, return to idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_land_x <= '0;
            r_hold   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state <= FLIGHT;
                        r_busy  <= 1'b1;
                    end
                end
                FLIGHT: begin
                    if (w_landed) begin
                        r_state  <= LANDED;
                        r_done   <= 1'b1;
                        r_land_x <= 11'(w_land_x);
                        r_hold   <= '0;
                    end
                end
                LANDED: begin
                    if (w_tick) begin
                        if (r_hold == C_HOLD_LAST) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hold <= r_hold + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sprite hit test in signed space so a sprite partly above the screen still clips correctly.
    always_comb begin
        w_h      = $signed({2'b00, vga_in.hcount});
        w_v      = $signed({2'b00, vga_in.vcount});
        w_x13    = {w_x[11], w_x};
        w_y13    = {w_y[11], w_y};
        w_active = (r_state != IDLE)
                 & (w_h >= w_x13) & (w_h < w_x13 + 13'(PROJ_SIZE))
                 & (w_v >= w_y13) & (w_v < w_y13 + 13'(PROJ_SIZE))
                 & ~vga_in.hblnk & ~vga_in.vblnk;
    end

    // One-cycle output register stage with the sprite colour overlaid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_hcount <= vga_in.hcount;
            r_vcount <= vga_in.vcount;
            r_hsync  <= vga_in.hsync;
            r_vsync  <= vga_in.vsync;
            r_hblnk  <= vga_in.hblnk;
            r_vblnk  <= vga_in.vblnk;
            r_rgb    <= w_active ? PROJ_COLOR : vga_in.rgb;
        end
    end

    assign vga_out.hcount = r_hcount;
    assign vga_out.vcount = r_vcount;
    assign vga_out.hsync  = r_hsync;
    assign vga_out.vsync  = r_vsync;
    assign vga_out.hblnk  = r_hblnk;
    assign vga_out.vblnk  = r_vblnk;
    assign vga_out.rgb    = r_rgb;

    assign busy   = r_busy;
    assign done   = r_done;
    assign land_x = r_land_x;

endmodule

// File: tb/tb_draw_projectile_dog.sv
// Bench for the dog projectile stage: closed-form trajectory model, pixel probes.
module tb_draw_projectile_dog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        launch = 1'b0;
    logic [9:0]  throw_force = '0;
    logic        busy;
    logic        done;
    logic [10:0] land_x;

    vga_if vin();
    vga_if vout();

    draw_projectile_dog dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .launch      (launch),
        .throw_force (throw_force),
        .busy        (busy),
        .done        (done),
        .land_x      (land_x),
        .vga_in      (vin),
        .vga_out     (vout)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] SPRITE = 12'h840;
    localparam logic [11:0] BG     = 12'h5A5;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Count every cycle on which done is high.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Closed-form flight: after k frames x = 876 - vx*k, y = 380 - 12k + k(k-1)/2.
    function automatic void model_flight(input int vx, output int ticks, output int lx, output int ly);
        int x, y;
        ticks = -1; lx = 0; ly = 0;
        for (int k = 1; k < 200; k++) begin
            x = 876 - vx * k;
            y = 380 - 12 * k + (k * (k - 1)) / 2;
            if (y >= 560) begin
                ticks = k; lx = (x < 0) ? 0 : x; ly = 560;
                return;
            end
            if (x <= 0) begin
                ticks = k; lx = 0; ly = y;
                return;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_tick(output logic d);
        vin.vblnk = 1'b1;
        step();
        d = done;
        vin.vblnk = 1'b0;
        step();
    endtask

    task automatic probe(input int h, input int v, input logic hb, output logic [11:0] rgb);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.rgb    = BG;
        step();
        rgb = vout.rgb;
        vin.hblnk = 1'b0;
    endtask

    task automatic do_launch(input logic [9:0] f);
        launch = 1'b1;
        throw_force = f;
        step();
        launch = 1'b0;
        throw_force = 10'(f + 10'd5);
        $display("launch force=%0d busy=%0b", f, busy);
    endtask

    task automatic check_pixel(input string name, input int h, input int v, input logic hb, input logic [11:0] exp);
        logic [11:0] got;
        probe(h, v, hb, got);
        n_checks++;
        if (got !== exp) $display("FAIL %s pixel(%0d,%0d) got=%h expected=%h", name, h, v, got, exp);
        else n_pass++;
    endtask

    // Tick frames until done; k0 frames were already flown before this call.
    task automatic fly_to_landing(input string name, input int k0, input int exp_ticks, input int exp_lx);
        logic d;
        int   k;
        k = k0;
        d = 1'b0;
        while (!d && k < 200) begin
            frame_tick(d);
            k++;
        end
        $display("%s landed after %0d ticks land_x=%0d", name, k, land_x);
        n_checks++;
        if (!d || k != exp_ticks) $display("FAIL %s landing_tick got=%0d expected=%0d", name, k, exp_ticks);
        else n_pass++;
        n_checks++;
        if (land_x !== 11'(exp_lx)) $display("FAIL %s land_x got=%0d expected=%0d", name, land_x, exp_lx);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s done_width got=%0b expected=0", name, done);
        else n_pass++;
    endtask

    // Count hold frames until busy drops; optionally launch on the very next cycle.
    task automatic wait_hold(input string name, input logic [9:0] relaunch_force);
        int n;
        n = 0;
        while (n < 60) begin
            vin.vblnk = 1'b1;
            step();
            n++;
            if (busy === 1'b0) break;
            vin.vblnk = 1'b0;
            step();
        end
        vin.vblnk = 1'b0;
        launch = (relaunch_force != 0);
        throw_force = relaunch_force;
        step();
        launch = 1'b0;
        n_checks++;
        if (n != 30) $display("FAIL %s hold_frames got=%0d expected=30", name, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vin.hcount = 11'd77; vin.vcount = 11'd99; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b1; vin.vblnk = 1'b0; vin.rgb = 12'hFFF;
        launch = 1'b1; throw_force = 10'd64;
        step(); step();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy got=%0b expected=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset done got=%0b expected=0", done); else n_pass++;
        n_checks++; if (land_x !== 11'd0) $display("FAIL reset land_x got=%0d expected=0", land_x); else n_pass++;
        n_checks++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== 39'd0)
            $display("FAIL reset vga_out got=%h expected=0",
                     {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
        else n_pass++;
        launch = 1'b0; throw_force = '0;
        vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0;
        rst_n = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_passthrough();
        logic [38:0] prev, cur, got;
        prev = '0;
        for (int i = 0; i < 20; i++) begin
            cur = {11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 4'($urandom), 12'($urandom)};
            {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb} = cur;
            step();
            got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
            n_checks++;
            if (got !== cur) $display("FAIL passthrough[%0d] got=%h expected=%h", i, got, cur);
            else n_pass++;
            prev = cur;
        end
        $display("passthrough last=%h", prev);
        {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb} = '0;
        step();
    endtask

    task automatic test_ignored_zero();
        logic d;
        do_launch(10'd0);
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_force busy got=%0b expected=0", busy); else n_pass++;
        frame_tick(d);
        check_pixel("zero_force", 876, 380, 1'b0, BG);
    endtask

    task automatic test_ground();
        int c0;
        c0 = done_cnt;
        do_launch(10'd64);
        n_checks++; if (busy !== 1'b1) $display("FAIL ground busy got=%0b expected=1", busy); else n_pass++;
        check_pixel("ground_start", 876, 380, 1'b0, SPRITE);
        check_pixel("ground_hblank", 876, 380, 1'b1, BG);
        check_pixel("ground_right_edge", 892, 380, 1'b0, BG);
        fly_to_landing("ground", 0, 36, 300);
        check_pixel("ground_landed", 300, 560, 1'b0, SPRITE);
        check_pixel("ground_left_of", 299, 560, 1'b0, BG);
        check_pixel("ground_below", 300, 576, 1'b0, BG);
        wait_hold("ground", 10'd0);
        n_checks++;
        if (done_cnt - c0 != 1) $display("FAIL ground done_pulses got=%0d expected=1", done_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_wall_and_relaunch();
        do_launch(10'd128);
        fly_to_landing("wall", 0, 28, 0);
        check_pixel("wall_y", 0, 422, 1'b0, SPRITE);
        check_pixel("wall_above", 0, 421, 1'b0, BG);
        wait_hold("wall", 10'd64);
        n_checks++; if (busy !== 1'b1) $display("FAIL relaunch busy got=%0b expected=1", busy); else n_pass++;
        check_pixel("relaunch_pos", 876, 380, 1'b0, SPRITE);
        check_pixel("relaunch_left", 875, 380, 1'b0, BG);
        check_pixel("relaunch_top", 876, 379, 1'b0, BG);
        fly_to_landing("relaunch", 0, 36, 300);
        wait_hold("relaunch", 10'd0);
    endtask

    task automatic test_second_launch();
        logic d;
        int c0;
        c0 = done_cnt;
        do_launch(10'd64);
        for (int i = 0; i < 5; i++) frame_tick(d);
        do_launch(10'd128);
        fly_to_landing("second_launch", 5, 36, 300);
        wait_hold("second_launch", 10'd0);
        n_checks++;
        if (done_cnt - c0 != 1) $display("FAIL second_launch done_pulses got=%0d expected=1", done_cnt - c0);
        else n_pass++;
    endtask

    task automatic test_random_force();
        int f, t, lx, ly;
        for (int i = 0; i < 4; i++) begin
            f = $urandom_range(1, 1023);
            model_flight(f >> 2, t, lx, ly);
            do_launch(10'(f));
            fly_to_landing("random", 0, t, lx);
            check_pixel("random_landed", lx, ly, 1'b0, SPRITE);
            wait_hold("random", 10'd0);
        end
    endtask

    task automatic test_reset_mid_flight();
        logic d;
        int c0;
        do_launch(10'd64);
        for (int i = 0; i < 10; i++) frame_tick(d);
        check_pixel("midflight_pos", 716, 305, 1'b0, SPRITE);
        c0 = done_cnt;
        vin.hcount = 11'd716; vin.vcount = 11'd305; vin.hsync = 1'b1; vin.rgb = 12'h123;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset busy got=%0b expected=0", busy); else n_pass++;
        n_checks++; if (land_x !== 11'd0) $display("FAIL midreset land_x got=%0d expected=0", land_x); else n_pass++;
        n_checks++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== 39'd0)
            $display("FAIL midreset vga_out got=%h expected=0",
                     {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb});
        else n_pass++;
        vin.hsync = 1'b0;
        for (int i = 0; i < 40; i++) frame_tick(d);
        n_checks++;
        if (done_cnt != c0) $display("FAIL midreset done_pulses got=%0d expected=0", done_cnt - c0);
        else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset busy_after got=%0b expected=0", busy); else n_pass++;
        check_pixel("midreset_sprite_off", 716, 305, 1'b0, BG);
    endtask

    initial begin
        {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb} = '0;
        test_reset();
        test_passthrough();
        test_ignored_zero();
        test_ground();
        test_wall_and_relaunch();
        test_second_launch();
        test_random_force();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #2000000;
        $display("FAIL timeout got=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule
